// File: rtl/template_match_ctrl_if.sv
// template_match_if: line, accumulator and result signals; master = controller, slave = source/datapath/consumer
interface template_match_if #(
  parameter int NUM_OF_LINES = 5,
  parameter int NUM_TEMPLATES = 4,
  parameter int ACC_W = 21
);
  logic line_valid;
  logic line_ready;
  logic acc_clear;
  logic acc_en;
  logic [$clog2(NUM_OF_LINES)-1:0] line_idx;
  logic [ACC_W-1:0] acc_sum_I_square;
  logic [ACC_W-1:0] acc_sum_I;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] acc_sum_TxI;
  logic res_valid;
  logic res_ready;
  logic [ACC_W-1:0] res_sum_I_square;
  logic [ACC_W-1:0] res_sum_I;
  logic [NUM_TEMPLATES-1:0][ACC_W-1:0] res_sum_TxI;
  logic [15:0] frame_cnt;
  modport master (
    input line_valid, acc_sum_I_square, acc_sum_I, acc_sum_TxI, res_ready,
    output line_ready, acc_clear, acc_en, line_idx, res_valid, res_sum_I_square, res_sum_I, res_sum_TxI, frame_cnt
  );
  modport slave (
    output line_valid, acc_sum_I_square, acc_sum_I, acc_sum_TxI, res_ready,
    input line_ready, acc_clear, acc_en, line_idx, res_valid, res_sum_I_square, res_sum_I, res_sum_TxI, frame_cnt
  );
endinterface

// File: rtl/template_match_ctrl.sv
// template_match_ctrl: frame sequencer for the template-match accumulators; ports CLK, reset (sync active-low), bus (line valid/ready/idx, acc clear/en/sums, held result valid/ready/sums, frame_cnt)
module template_match_ctrl #(
  parameter int NUM_OF_LINES = 5,
  parameter int LINE_SIZE = 4,
  parameter int PIXEL_SIZE = 8,
  parameter int NUM_TEMPLATES = 4,
  parameter int ACC_LATENCY = 2,
  parameter int ACC_W = $clog2(NUM_OF_LINES) + $clog2(LINE_SIZE) + 2 * PIXEL_SIZE
) (
  input logic CLK,
  input logic reset,
  template_match_if.master bus
);
  localparam int LW = $clog2(NUM_OF_LINES);
  localparam int DW = ACC_LATENCY > 1 ? $clog2(ACC_LATENCY) : 1;
  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] line_cnt, line_cnt_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic last_line, drain_done, capture;
  assign bus.acc_clear = state == CLEAR || !reset;
  assign bus.line_ready = state == ACCUM;
  assign bus.acc_en = bus.line_valid && bus.line_ready;
  assign bus.line_idx = line_cnt;
  assign last_line = line_cnt == LW'(NUM_OF_LINES - 1);
  assign drain_done = drain_cnt == DW'(ACC_LATENCY - 1);
  assign capture = state == DRAIN && drain_done && (!bus.res_valid || bus.res_ready);
  always_comb begin
    state_nxt = state == CLEAR ? ACCUM
              : state == ACCUM && bus.acc_en && last_line ? DRAIN
              : capture ? CLEAR : state;
    line_cnt_nxt = bus.acc_en ? (last_line ? '0 : line_cnt + 1'b1) : line_cnt;
    drain_cnt_nxt = state != DRAIN ? '0 : drain_done ? drain_cnt : drain_cnt + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= CLEAR;
      line_cnt <= '0;
      drain_cnt <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sum_I <= ACC_W'(0);
      bus.res_sum_I_square <= ACC_W'(0);
      bus.res_sum_TxI <= {NUM_TEMPLATES{ACC_W'(0)}};
      bus.frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      line_cnt <= line_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (capture) begin
        bus.res_valid <= 1'b1;
        bus.res_sum_I <= bus.acc_sum_I;
        bus.res_sum_I_square <= bus.acc_sum_I_square;
        bus.res_sum_TxI <= bus.acc_sum_TxI;
        bus.frame_cnt <= bus.frame_cnt + 1'b1;
      end else if (bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_template_match_ctrl.sv
// tb_template_match_ctrl: randomized and directed checks of template_match_ctrl against a frame-level reference model
module tb_template_match_ctrl;
  localparam int NL = 5;
  localparam int LS = 4;
  localparam int PS = 8;
  localparam int NT = 4;
  localparam int LAT = 2;
  localparam int AW = $clog2(NL) + $clog2(LS) + 2 * PS;
  localparam int IW = $clog2(NL);
  localparam int CW = 4 + IW + 16;
  localparam int RW = (2 + NT) * AW;
  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;
  template_match_if #(.NUM_OF_LINES(NL), .NUM_TEMPLATES(NT), .ACC_W(AW)) bus_if ();
  template_match_ctrl #(
    .NUM_OF_LINES(NL), .LINE_SIZE(LS), .PIXEL_SIZE(PS), .NUM_TEMPLATES(NT), .ACC_LATENCY(LAT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus_if)
  );
  logic [PS-1:0] pix [LS];
  logic [PS-1:0] tmpl [NT][NL][LS];
  logic [PS-1:0] fr_pix [NL][LS];
  bit pix_max = 0;
  logic [AW-1:0] line_i, line_sq;
  logic [NT-1:0][AW-1:0] line_t;
  logic [AW-1:0] st_i [LAT];
  logic [AW-1:0] st_sq [LAT];
  logic [NT-1:0][AW-1:0] st_t [LAT];
  always_comb begin
    int li;
    li = int'(bus_if.line_idx) < NL ? int'(bus_if.line_idx) : 0;
    line_i = '0;
    line_sq = '0;
    line_t = '0;
    for (int p = 0; p < LS; p++) begin
      line_i += AW'(pix[p]);
      line_sq += AW'(pix[p]) * AW'(pix[p]);
      for (int k = 0; k < NT; k++) line_t[k] += AW'(pix[p]) * AW'(tmpl[k][li][p]);
    end
  end
  always @(posedge CLK) begin
    if (bus_if.acc_clear) begin
      st_i[0] <= '0;
      st_sq[0] <= '0;
      st_t[0] <= '0;
    end else if (bus_if.acc_en) begin
      st_i[0] <= st_i[0] + line_i;
      st_sq[0] <= st_sq[0] + line_sq;
      for (int k = 0; k < NT; k++) st_t[0][k] <= st_t[0][k] + line_t[k];
    end
    for (int j = 1; j < LAT; j++) begin
      st_i[j] <= st_i[j-1];
      st_sq[j] <= st_sq[j-1];
      st_t[j] <= st_t[j-1];
    end
  end
  assign bus_if.acc_sum_I = st_i[LAT-1];
  assign bus_if.acc_sum_I_square = st_sq[LAT-1];
  assign bus_if.acc_sum_TxI = st_t[LAT-1];
  logic [CW-1:0] obs_ctl, e_ctl;
  logic [RW-1:0] obs_res, e_res, m_res;
  assign obs_ctl = {bus_if.line_ready, bus_if.acc_en, bus_if.acc_clear, bus_if.res_valid, bus_if.line_idx, bus_if.frame_cnt};
  assign obs_res = {bus_if.res_sum_I, bus_if.res_sum_I_square, bus_if.res_sum_TxI};
  logic [RW-1:0] exp_q [$];
  bit m_clear = 1, m_open = 0, m_rv = 0;
  int m_lines = 0, m_done = 0, cyc = 0;
  logic [15:0] m_frames = '0;
  int n_checks = 0, n_errors = 0;
  function automatic logic [RW-1:0] ref_frame();
    logic [AW-1:0] si, sq;
    logic [NT-1:0][AW-1:0] s_t;
    si = '0;
    sq = '0;
    s_t = '0;
    for (int l = 0; l < NL; l++)
      for (int p = 0; p < LS; p++) begin
        si += AW'(fr_pix[l][p]);
        sq += AW'(fr_pix[l][p]) * AW'(fr_pix[l][p]);
        for (int k = 0; k < NT; k++) s_t[k] += AW'(fr_pix[l][p]) * AW'(tmpl[k][l][p]);
      end
    return {si, sq, s_t};
  endfunction
  task automatic set_tmpl(input bit ones);
    for (int k = 0; k < NT; k++)
      for (int l = 0; l < NL; l++)
        for (int p = 0; p < LS; p++) tmpl[k][l][p] = ones ? PS'(1) : PS'($urandom);
  endtask
  task automatic drive(input logic rn, input logic lv, input logic rr);
    bit cap;
    @(negedge CLK);
    reset = rn;
    bus_if.line_valid = lv;
    bus_if.res_ready = rr;
    for (int p = 0; p < LS; p++) pix[p] = pix_max ? PS'(255) : PS'($urandom);
    #1;
    cyc++;
    e_ctl = {m_open, lv && m_open, m_clear || !rn, m_rv, IW'(m_lines), m_frames};
    e_res = m_res;
    if (!rn) begin
      m_clear = 1;
      m_open = 0;
      m_lines = 0;
      m_rv = 0;
      m_frames = '0;
      m_res = '0;
      exp_q.delete();
    end else begin
      cap = !m_open && !m_clear && exp_q.size() > 0 && cyc >= m_done + LAT && (!m_rv || rr);
      if (m_rv && rr) m_rv = 0;
      if (m_clear) begin
        m_clear = 0;
        m_open = 1;
      end else if (m_open && lv) begin
        for (int p = 0; p < LS; p++) fr_pix[m_lines][p] = pix[p];
        m_lines++;
        if (m_lines == NL) begin
          exp_q.push_back(ref_frame());
          m_lines = 0;
          m_open = 0;
          m_done = cyc;
        end
      end else if (cap) begin
        m_res = exp_q.pop_front();
        m_rv = 1;
        m_frames++;
        m_clear = 1;
      end
    end
  endtask
  task automatic do_reset();
    drive(0, 0, 1);
    drive(0, 0, 1);
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1);
      if (c > 0) begin
        n_checks++;
        if (obs_ctl !== {4'b0010, IW'(0), 16'd0} || obs_res !== '0) begin
          n_errors++;
          $display("FAIL reset c=%0d: ctl=%h res=%h, expected ctl=%h res=0", c, obs_ctl, obs_res, {4'b0010, IW'(0), 16'd0});
        end
      end
    end
  endtask
  task automatic test_defaults();
    logic [CW-1:0] want;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 1);
      want = {(c >= 1 && c <= 5) || c == 9, (c >= 1 && c <= 5) || c == 9, c == 0 || c == 8, c == 8,
              IW'((c >= 1 && c <= 5) ? c - 1 : 0), 16'(c >= 8)};
      n_checks++;
      if (obs_ctl !== want) begin
        n_errors++;
        $display("FAIL defaults c=%0d: ctl=%h expected %h", c, obs_ctl, want);
      end
      if (c == 8) begin
        n_checks++;
        if (obs_res !== e_res) begin
          n_errors++;
          $display("FAIL defaults_sums: res=%h expected %h", obs_res, e_res);
        end
      end
    end
  endtask
  task automatic test_max_pixels();
    pix_max = 1;
    set_tmpl(1);
    do_reset();
    for (int c = 0; c < 9; c++) drive(1, 1, 1);
    n_checks++;
    if (bus_if.res_sum_I !== AW'(5100) || bus_if.res_sum_I_square !== AW'(1300500)) begin
      n_errors++;
      $display("FAIL max_pixels: I=%0d I2=%0d expected 5100 1300500", bus_if.res_sum_I, bus_if.res_sum_I_square);
    end
    for (int k = 0; k < NT; k++) begin
      n_checks++;
      if (bus_if.res_sum_TxI[k] !== AW'(5100)) begin
        n_errors++;
        $display("FAIL max_pixels_TxI[%0d]: %0d expected 5100", k, bus_if.res_sum_TxI[k]);
      end
    end
    pix_max = 0;
    set_tmpl(0);
  endtask
  task automatic test_gaps();
    int n_en = 0, t5 = -100;
    logic [15:0] prev_fc = '0;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      drive(1, c % 3 == 1, 1);
      n_checks++;
      if (obs_ctl !== e_ctl || obs_res !== e_res) begin
        n_errors++;
        $display("FAIL gaps c=%0d: ctl=%h res=%h expected ctl=%h res=%h", c, obs_ctl, obs_res, e_ctl, e_res);
      end
      if (bus_if.frame_cnt !== prev_fc) begin
        n_checks++;
        if (n_en != NL * int'(bus_if.frame_cnt) || c != t5 + LAT + 1) begin
          n_errors++;
          $display("FAIL gaps_capture c=%0d: lines=%0d frames=%0d, expected lines=%0d at cycle %0d", c, n_en, bus_if.frame_cnt, NL * int'(bus_if.frame_cnt), t5 + LAT + 1);
        end
        prev_fc = bus_if.frame_cnt;
      end
      if (bus_if.acc_en === 1'b1) begin
        n_en++;
        if (n_en % NL == 0) t5 = c;
      end
    end
    n_checks++;
    if (bus_if.frame_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL gaps_frames: frame_cnt=%0d expected 2", bus_if.frame_cnt);
    end
  endtask
  task automatic test_backpressure();
    logic [RW-1:0] f1;
    f1 = '0;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(1, 1, c < 8 || c >= 20);
      if (c == 8) f1 = e_res;
      n_checks++;
      if (obs_ctl !== e_ctl || obs_res !== e_res) begin
        n_errors++;
        $display("FAIL backpressure c=%0d: ctl=%h res=%h expected ctl=%h res=%h", c, obs_ctl, obs_res, e_ctl, e_res);
      end
      if (c >= 16 && c <= 20) begin
        n_checks++;
        if ({bus_if.line_ready, bus_if.acc_clear, bus_if.res_valid, bus_if.frame_cnt} !== {3'b001, 16'd1} || obs_res !== f1) begin
          n_errors++;
          $display("FAIL backpressure_hold c=%0d: rdy/clr/rv=%b%b%b fc=%0d res=%h expected 001 fc=1 res=%h", c, bus_if.line_ready, bus_if.acc_clear, bus_if.res_valid, bus_if.frame_cnt, obs_res, f1);
        end
      end
      if (c == 21) begin
        n_checks++;
        if ({bus_if.acc_clear, bus_if.res_valid, bus_if.frame_cnt} !== {2'b11, 16'd2}) begin
          n_errors++;
          $display("FAIL backpressure_release: clr/rv=%b%b fc=%0d expected 11 fc=2", bus_if.acc_clear, bus_if.res_valid, bus_if.frame_cnt);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      drive(!(c == 12 || c == 13), 1, 0);
      n_checks++;
      if (obs_ctl !== e_ctl || obs_res !== e_res) begin
        n_errors++;
        $display("FAIL reset_mid c=%0d: ctl=%h res=%h expected ctl=%h res=%h", c, obs_ctl, obs_res, e_ctl, e_res);
      end
      if (c == 13) begin
        n_checks++;
        if ({bus_if.acc_clear, bus_if.res_valid, bus_if.line_idx, bus_if.frame_cnt} !== {2'b10, IW'(0), 16'd0}) begin
          n_errors++;
          $display("FAIL reset_mid_drop: clr=%b rv=%b idx=%0d fc=%0d expected 1 0 0 0", bus_if.acc_clear, bus_if.res_valid, bus_if.line_idx, bus_if.frame_cnt);
        end
      end
      if (c == 14) begin
        n_checks++;
        if ({bus_if.acc_clear, bus_if.line_ready} !== 2'b10) begin
          n_errors++;
          $display("FAIL reset_mid_release: clr=%b rdy=%b expected 1 0", bus_if.acc_clear, bus_if.line_ready);
        end
      end
      if (c == 21 || c == 22) begin
        n_checks++;
        if ({bus_if.res_valid, bus_if.frame_cnt} !== {c == 22, 16'(c == 22)}) begin
          n_errors++;
          $display("FAIL reset_mid_refill c=%0d: rv=%b fc=%0d expected rv=%0d fc=%0d", c, bus_if.res_valid, bus_if.frame_cnt, c == 22, c == 22);
        end
      end
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(1, 1, 1);
      if (c >= 3) begin
        n_checks++;
        if (obs_ctl !== e_ctl || bus_if.frame_cnt !== (c >= 8 ? 16'h0000 : 16'hFFFF)) begin
          n_errors++;
          $display("FAIL wrap c=%0d: ctl=%h fc=%h expected ctl=%h fc=%h", c, obs_ctl, bus_if.frame_cnt, e_ctl, c >= 8 ? 16'h0000 : 16'hFFFF);
        end
      end
      if (c == 2) begin
        force bus_if.frame_cnt = 16'hFFFF;
        #1;
        release bus_if.frame_cnt;
        m_frames = 16'hFFFF;
      end
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(c < 2 ? 1'b0 : 1'($urandom % 150 != 0), 1'($urandom % 4 != 0), 1'($urandom % 3 != 0));
      if (c >= 1) begin
        n_checks++;
        if (obs_ctl !== e_ctl || obs_res !== e_res) begin
          n_errors++;
          $display("FAIL random c=%0d: ctl=%h res=%h expected ctl=%h res=%h", c, obs_ctl, obs_res, e_ctl, e_res);
        end
      end
    end
  endtask
  initial begin
    bus_if.line_valid = 1'b0;
    bus_if.res_ready = 1'b0;
    set_tmpl(0);
    test_reset();
    test_defaults();
    test_max_pixels();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/template_match_ctrl.md
Name: template_match_ctrl

Overview:
- Frame sequencer for the template-matching accumulator datapath (I, I², T×I line sums across NUM_TEMPLATES).
- Accepts image/template lines from an upstream source with a valid/ready handshake, and drives the datapath clear and line-enable strobes.
- Waits out the datapath pipeline after the last line of a frame, then captures the accumulated sums into a held result register with a valid/ready output handshake.
- Replaces the free-running periodic accumulator clear.

Parameters:
- NUM_OF_LINES, 5: lines per frame (≥2).
- LINE_SIZE, 4: pixels per line; used only for width.
- PIXEL_SIZE, 8: bits per pixel.
- NUM_TEMPLATES, 4: number of templates.
- ACC_LATENCY, 2: cycles from acc_en to the sum being valid at the datapath output (≥1).
- ACC_W, $clog2(NUM_OF_LINES)+$clog2(LINE_SIZE)+2*PIXEL_SIZE: accumulator width.

Ports:
- CLK, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-low reset.
- line_valid, in, 1: upstream line present.
- line_ready, out, 1: controller accepts line.
- acc_clear, out, 1: clear datapath accumulators.
- acc_en, out, 1: datapath consumes the current line this cycle.
- line_idx, out, $clog2(NUM_OF_LINES): index of the next line to accept.
- acc_sum_I_square, in, ACC_W: datapath I² sum.
- acc_sum_I, in, ACC_W: datapath I sum.
- acc_sum_TxI, in, ACC_W×[NUM_TEMPLATES]: datapath T×I sums.
- res_valid, out, 1: result held.
- res_ready, in, 1: consumer takes result.
- res_sum_I_square, out, ACC_W: captured I² sum.
- res_sum_I, out, ACC_W: captured I sum.
- res_sum_TxI, out, ACC_W×[NUM_TEMPLATES]: captured T×I sums.
- frame_cnt, out, 16: captured-frame count; wraps 0xFFFF→0.

Behaviour:
- All state changes on the rising edge of CLK. reset==0 sampled at an edge puts the block in reset state:
  - state=CLEAR, line_cnt=0, drain_cnt=0.
  - res_valid=0, res_* =0, frame_cnt=0.
- acc_clear = (state==CLEAR) || !reset, combinational. The datapath is held cleared throughout reset.
- line_ready = (state==ACCUM). acc_en = line_valid && line_ready, combinational. line_idx = line_cnt.
- State CLEAR: lasts 1 cycle → ACCUM.
- State ACCUM:
  - Each handshake (line_valid && line_ready): line_cnt++.
  - Handshake with line_cnt==NUM_OF_LINES-1: line_cnt←0, drain_cnt←0, → DRAIN.
  - No handshake: hold. Gaps in line_valid are legal at any point.
- State DRAIN:
  - line_ready=0, acc_en=0.
  - drain_cnt increments until it reaches ACC_LATENCY-1, then saturates.
  - Capture condition: drain_cnt==ACC_LATENCY-1 && (!res_valid || res_ready).
  - On capture:
    - res_sum_* ← acc_sum_* (values sampled that cycle).
    - res_valid←1, frame_cnt++.
    - → CLEAR.
  - If drain_cnt is at its limit but res_valid && !res_ready: stay in DRAIN. The datapath holds its sums because acc_en=0.
- res_valid handling:
  - res_valid && res_ready without a capture in the same cycle: res_valid←0; res_sum_* keep their values.
  - Simultaneous handshake and capture: res_valid stays 1 and res_sum_* take the new values.
  - res_sum_* change only on capture.
- Minimum frame period with back-to-back lines and res_ready=1: 1 + NUM_OF_LINES + ACC_LATENCY cycles.
- Reset mid-frame (any state): partial frame discarded, state→CLEAR, pending result dropped (res_valid←0).
- No arithmetic is done here. Sums pass through at ACC_W width; no truncation.

Test Plan:
1. Defaults. Release reset at cycle 0, line_valid=1 continuously, res_ready=1 → acc_clear=1 in cycle 0; line_ready=1 in cycles 1–5; acc_en pulses on 5 lines; DRAIN in cycles 6–7; res_valid=1 from cycle 8; acc_clear=1 in cycle 8; frame_cnt=1.
2. Datapath model, all pixels 255 (LINE_SIZE=4), templates all 1 → res_sum_I=5100, res_sum_I_square=1300500, res_sum_TxI[k]=5100 for all k.
3. line_valid toggled 1,0,0,1,… → line_idx advances only on handshakes; exactly 5 acc_en pulses per frame; capture occurs ACC_LATENCY cycles after the 5th acc_en.
4. res_ready=0 through the end of frame 2 → frame 1 results stay stable, state holds in DRAIN, line_ready=0. Raise res_ready → in that same cycle frame 2 is captured, res_valid stays 1, frame_cnt=2.
5. Pull reset low after 3 accepted lines (cycle 4), release at cycle 6 → line_idx=0, res_valid=0, acc_clear=1 while reset is low and for 1 cycle after release; the next frame requires 5 new lines.
6. Run 65536 frames (or force frame_cnt=0xFFFF) → next capture gives frame_cnt=0.
